// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed packets until both sources are ready,
// wakes operands from the CDB and offers the oldest ready entry to the ALU.
package alu_rs_pkg;
    localparam int PKG_TAG_W = 7;
    localparam int PKG_ROB_W = 5;

    typedef struct packed {
        logic [31:0]          pc;
        logic [PKG_TAG_W-1:0] rs1_tag;
        logic                 rs1_ready;
        logic [PKG_TAG_W-1:0] rs2_tag;
        logic                 rs2_ready;
        logic [PKG_TAG_W-1:0] rd_new_tag;
        logic                 rd_used;
    } rename_pkt_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [PKG_ROB_W-1:0] rob_tag;
        logic [PKG_TAG_W-1:0] rs1_tag;
        logic [PKG_TAG_W-1:0] rs2_tag;
        logic [PKG_TAG_W-1:0] rd_tag;
    } issue_pkt_t;
endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = PKG_TAG_W,
    parameter int ROB_W = PKG_ROB_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  rename_pkt_t      disp_pkt_i,
    input  logic [ROB_W-1:0] disp_rob_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output issue_pkt_t       issue_pkt_o,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rs1_rdy_q;
    logic [DEPTH-1:0] rs2_rdy_q;
    logic [DEPTH-1:0] rd_used_q;
    logic [31:0]      pc_q      [DEPTH];
    logic [ROB_W-1:0] rob_q     [DEPTH];
    logic [TAG_W-1:0] rs1_tag_q [DEPTH];
    logic [TAG_W-1:0] rs2_tag_q [DEPTH];
    logic [TAG_W-1:0] rd_tag_q  [DEPTH];
    // age_q[i][j] = 1: entry i is older than entry j
    logic [DEPTH-1:0] age_q     [DEPTH];
    logic [CNT_W-1:0] count_q;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] older_ready;
    logic [DEPTH-1:0] cdb_hit1;
    logic [DEPTH-1:0] cdb_hit2;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire;
    logic             issue_fire;
    logic             disp_rs1_rdy;
    logic             disp_rs2_rdy;

    // Both ports are valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high and flush_i is low. Valid does not wait
    // for ready, and the issue offer may change while ready is low.
    assign disp_ready_o = (count_q < CNT_W'(DEPTH));
    assign count_o      = count_q;
    assign ready_vec    = valid_q & rs1_rdy_q & rs2_rdy_q;
    assign issue_valid_o = |ready_vec;
    assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;
    assign issue_fire   = issue_valid_o & issue_ready_i & ~flush_i;

    assign disp_rs1_rdy = disp_pkt_i.rs1_ready |
                          (cdb_valid_i && (TAG_W'(disp_pkt_i.rs1_tag) == cdb_tag_i));
    assign disp_rs2_rdy = disp_pkt_i.rs2_ready |
                          (cdb_valid_i && (TAG_W'(disp_pkt_i.rs2_tag) == cdb_tag_i));

    always_comb begin
        cdb_hit1 = '0;
        cdb_hit2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cdb_hit1[i] = cdb_valid_i && (rs1_tag_q[i] == cdb_tag_i);
            cdb_hit2[i] = cdb_valid_i && (rs2_tag_q[i] == cdb_tag_i);
        end
    end

    // An entry loses the select if any older entry is also ready.
    always_comb begin
        older_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_ready[i] = older_ready[i] | (ready_vec[j] & age_q[j][i]);
            end
        end
    end

    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i] && !older_ready[i]) sel_idx = IDX_W'(i);
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        issue_pkt_o = '0;
        if (issue_valid_o) begin
            issue_pkt_o.pc      = pc_q[sel_idx];
            issue_pkt_o.rob_tag = PKG_ROB_W'(rob_q[sel_idx]);
            issue_pkt_o.rs1_tag = PKG_TAG_W'(rs1_tag_q[sel_idx]);
            issue_pkt_o.rs2_tag = PKG_TAG_W'(rs2_tag_q[sel_idx]);
            issue_pkt_o.rd_tag  = rd_used_q[sel_idx] ? PKG_TAG_W'(rd_tag_q[sel_idx]) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            age_q     <= '{default: '0};
            count_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_hit1[i]) rs1_rdy_q[i] <= 1'b1;
                if (valid_q[i] && cdb_hit2[i]) rs2_rdy_q[i] <= 1'b1;
            end
            if (issue_fire) valid_q[sel_idx] <= 1'b0;
            // The free slot is never the selected one, so these writes do not collide.
            if (disp_fire) begin
                valid_q[free_idx]   <= 1'b1;
                rs1_rdy_q[free_idx] <= disp_rs1_rdy;
                rs2_rdy_q[free_idx] <= disp_rs2_rdy;
                age_q[free_idx]     <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (valid_q[j]) age_q[j][free_idx] <= 1'b1;
                end
            end
            count_q <= count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (disp_fire) begin
            pc_q[free_idx]      <= disp_pkt_i.pc;
            rob_q[free_idx]     <= disp_rob_tag_i;
            rs1_tag_q[free_idx] <= TAG_W'(disp_pkt_i.rs1_tag);
            rs2_tag_q[free_idx] <= TAG_W'(disp_pkt_i.rs2_tag);
            rd_tag_q[free_idx]  <= TAG_W'(disp_pkt_i.rd_new_tag);
            rd_used_q[free_idx] <= disp_pkt_i.rd_used;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: single-entry vector table plus hand-written
// sequences for wakeup timing, age order, full, flush and async reset.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        disp_valid;
    logic        disp_ready;
    rename_pkt_t disp_pkt;
    logic [4:0]  disp_rob_tag;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic        issue_valid;
    logic        issue_ready;
    issue_pkt_t  issue_pkt;
    logic        flush;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    alu_rs #(.DEPTH(8), .TAG_W(7), .ROB_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .disp_valid_i   (disp_valid),
        .disp_ready_o   (disp_ready),
        .disp_pkt_i     (disp_pkt),
        .disp_rob_tag_i (disp_rob_tag),
        .cdb_valid_i    (cdb_valid),
        .cdb_tag_i      (cdb_tag),
        .issue_valid_o  (issue_valid),
        .issue_ready_i  (issue_ready),
        .issue_pkt_o    (issue_pkt),
        .flush_i        (flush),
        .count_o        (count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  rs1_tag;
        logic        rs1_rdy;
        logic [6:0]  rs2_tag;
        logic        rs2_rdy;
        logic [6:0]  rd_tag;
        logic        rd_used;
        logic [4:0]  rob;
        logic        use_cdb;
        logic [6:0]  cdb_tag;
        logic [6:0]  exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [31:0] pc, input logic [6:0] t1, input logic r1,
                              input logic [6:0] t2, input logic r2, input logic [6:0] rd,
                              input logic ru, input logic [4:0] rob);
        disp_valid          = 1'b1;
        disp_pkt.pc         = pc;
        disp_pkt.rs1_tag    = t1;
        disp_pkt.rs1_ready  = r1;
        disp_pkt.rs2_tag    = t2;
        disp_pkt.rs2_ready  = r2;
        disp_pkt.rd_new_tag = rd;
        disp_pkt.rd_used    = ru;
        disp_rob_tag        = rob;
    endtask

    task automatic idle_inputs();
        disp_valid  = 1'b0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        issue_ready = 1'b0;
        flush       = 1'b0;
    endtask

    // scoreboard: every accepted issue must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready && !flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", issue_pkt.pc, 32'hDEAD_DEAD);
            end else begin
                check("issue_order", issue_pkt.pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 7'd1,  1'b1, 7'd2,  1'b1, 7'd20,  1'b1, 5'd3,  1'b0, 7'd0,  7'd20};
        vecs[1] = '{32'h0000_0104, 7'd3,  1'b1, 7'd4,  1'b1, 7'd33,  1'b0, 5'd4,  1'b0, 7'd0,  7'd0};
        vecs[2] = '{32'h0000_0108, 7'd12, 1'b0, 7'd6,  1'b1, 7'd21,  1'b1, 5'd5,  1'b1, 7'd12, 7'd21};
        vecs[3] = '{32'h0000_010C, 7'd9,  1'b0, 7'd9,  1'b0, 7'd22,  1'b1, 5'd6,  1'b1, 7'd9,  7'd22};
        vecs[4] = '{32'h0000_0110, 7'd8,  1'b1, 7'd40, 1'b0, 7'd23,  1'b1, 5'd7,  1'b1, 7'd40, 7'd23};
        vecs[5] = '{32'hFFFF_FFFC, 7'd10, 1'b1, 7'd11, 1'b1, 7'd127, 1'b1, 5'd31, 1'b0, 7'd0,  7'd127};

        rst_n        = 1'b0;
        disp_pkt     = '0;
        disp_rob_tag = '0;
        idle_inputs();
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_disp_ready", 32'(disp_ready), 1);
        check("rst_issue_valid", 32'(issue_valid), 0);
        check("rst_issue_pkt", 32'(issue_pkt.pc), 0);
        rst_n = 1'b1;
        tick();

        // single-entry vectors: dispatch, observe offer, issue, observe empty
        for (int v = 0; v < 6; v++) begin
            drive_disp(vecs[v].pc, vecs[v].rs1_tag, vecs[v].rs1_rdy, vecs[v].rs2_tag,
                       vecs[v].rs2_rdy, vecs[v].rd_tag, vecs[v].rd_used, vecs[v].rob);
            cdb_valid = vecs[v].use_cdb;
            cdb_tag   = vecs[v].cdb_tag;
            check("vec_empty_no_issue", 32'(issue_valid), 0);
            tick();
            idle_inputs();
            check("vec_count1", 32'(count), 1);
            check("vec_issue_valid", 32'(issue_valid), 1);
            check("vec_pc", issue_pkt.pc, vecs[v].pc);
            check("vec_rob", 32'(issue_pkt.rob_tag), 32'(vecs[v].rob));
            check("vec_rs1", 32'(issue_pkt.rs1_tag), 32'(vecs[v].rs1_tag));
            check("vec_rs2", 32'(issue_pkt.rs2_tag), 32'(vecs[v].rs2_tag));
            check("vec_rd", 32'(issue_pkt.rd_tag), 32'(vecs[v].exp_rd));
            exp_q.push_back(vecs[v].pc);
            issue_ready = 1'b1;
            tick();
            issue_ready = 1'b0;
            check("vec_count0", 32'(count), 0);
            check("vec_idle", 32'(issue_valid), 0);
        end

        // wakeup two cycles after dispatch: must not issue before broadcast
        drive_disp(32'h200, 7'd12, 1'b0, 7'd1, 1'b1, 7'd30, 1'b1, 5'd8);
        issue_ready = 1'b1;
        tick();
        disp_valid = 1'b0;
        check("wake_wait0", 32'(issue_valid), 0);
        tick();
        check("wake_wait1", 32'(issue_valid), 0);
        cdb_valid = 1'b1;
        cdb_tag   = 7'd12;
        exp_q.push_back(32'h200);
        tick();
        cdb_valid = 1'b0;
        check("wake_valid", 32'(issue_valid), 1);
        check("wake_pc", issue_pkt.pc, 32'h200);
        tick();
        issue_ready = 1'b0;
        check("wake_count0", 32'(count), 0);

        // age order: A waits on tag 5, B and C ready
        drive_disp(32'h300, 7'd5, 1'b0, 7'd1, 1'b1, 7'd31, 1'b1, 5'd9);
        tick();
        drive_disp(32'h304, 7'd1, 1'b1, 7'd2, 1'b1, 7'd32, 1'b1, 5'd10);
        tick();
        drive_disp(32'h308, 7'd1, 1'b1, 7'd2, 1'b1, 7'd33, 1'b1, 5'd11);
        tick();
        disp_valid = 1'b0;
        check("age_offer_b", issue_pkt.pc, 32'h304);
        check("age_count3", 32'(count), 3);
        cdb_valid = 1'b1;
        cdb_tag   = 7'd5;
        tick();
        cdb_valid = 1'b0;
        check("age_offer_a", issue_pkt.pc, 32'h300);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        issue_ready = 1'b1;
        tick();
        check("age_second_b", issue_pkt.pc, 32'h304);
        tick();
        check("age_third_c", issue_pkt.pc, 32'h308);
        tick();
        issue_ready = 1'b0;
        check("age_count0", 32'(count), 0);

        // full boundary and backpressure
        for (int i = 0; i < 8; i++) begin
            check("full_ready_before", 32'(disp_ready), 1);
            drive_disp(32'h400 + 32'(i * 4), 7'd1, 1'b1, 7'd2, 1'b1, 7'(i), 1'b1, 5'(i));
            tick();
        end
        check("full_count8", 32'(count), 8);
        check("full_not_ready", 32'(disp_ready), 0);
        check("full_offer", issue_pkt.pc, 32'h400);
        drive_disp(32'h500, 7'd1, 1'b1, 7'd2, 1'b1, 7'd50, 1'b1, 5'd20);
        tick();
        check("full_ninth_held", 32'(count), 8);
        issue_ready = 1'b1;
        exp_q.push_back(32'h400);
        tick();
        issue_ready = 1'b0;
        check("full_freed_count", 32'(count), 7);
        check("full_freed_ready", 32'(disp_ready), 1);
        tick();
        disp_valid = 1'b0;
        check("full_ninth_in", 32'(count), 8);
        check("full_ready_again", 32'(disp_ready), 0);
        check("full_next_oldest", issue_pkt.pc, 32'h404);
        for (int i = 1; i < 8; i++) exp_q.push_back(32'h400 + 32'(i * 4));
        exp_q.push_back(32'h500);
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        issue_ready = 1'b0;
        check("full_drained", 32'(count), 0);

        // flush overrides concurrent dispatch and issue
        for (int i = 0; i < 5; i++) begin
            drive_disp(32'h600 + 32'(i * 4), 7'd1, 1'b1, 7'd2, 1'b1, 7'd60, 1'b1, 5'(i));
            tick();
        end
        check("flush_count5", 32'(count), 5);
        drive_disp(32'h700, 7'd1, 1'b1, 7'd2, 1'b1, 7'd61, 1'b1, 5'd21);
        flush       = 1'b1;
        issue_ready = 1'b1;
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        check("flush_count0", 32'(count), 0);
        check("flush_no_issue", 32'(issue_valid), 0);
        check("flush_ready", 32'(disp_ready), 1);
        tick();
        issue_ready = 1'b0;
        check("flush_dropped", 32'(count), 0);

        // asynchronous reset mid-run
        for (int i = 0; i < 3; i++) begin
            drive_disp(32'h800 + 32'(i * 4), 7'd1, 1'b1, 7'd2, 1'b1, 7'd70, 1'b1, 5'(i));
            tick();
        end
        disp_valid = 1'b0;
        check("arst_pre_valid", 32'(issue_valid), 1);
        check("arst_pre_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_issue_valid", 32'(issue_valid), 0);
        check("arst_disp_ready", 32'(disp_ready), 1);
        check("arst_pkt", issue_pkt.pc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_post_count", 32'(count), 0);
        check("arst_post_ready", 32'(disp_ready), 1);
        check("arst_post_valid", 32'(issue_valid), 0);

        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the ALU pipe in the Phase 2 out-of-order core. Sits between dispatch, which delivers renamed packets, and the ALU issue port, which consumes issue packets. Holds up to DEPTH waiting instructions and wakes source operands from the common data bus (CDB) broadcast. Each cycle it offers the oldest fully-ready entry to the ALU.

## Interface
- DEPTH, 8, number of entries (power of two, 2..16)
- TAG_W, 7, physical register tag width (must match rename_pkt_t tag fields)
- ROB_W, 5, ROB index width
- CNT_W, $clog2(DEPTH+1), occupancy counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- disp_valid_i  in  1  dispatch offers a packet
- disp_ready_o  out  1  station can accept a packet this cycle
- disp_pkt_i  in  rename_pkt_t  renamed packet; uses pc, rs1_tag, rs1_ready, rs2_tag, rs2_ready, rd_new_tag, rd_used
- disp_rob_tag_i  in  ROB_W  ROB slot assigned to the packet
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  physical tag being produced
- issue_valid_o  out  1  a ready entry is offered
- issue_ready_i  in  1  ALU accepts the offered packet
- issue_pkt_o  out  issue_pkt_t  pc, rob_tag, rs1_tag, rs2_tag, rd_tag (= rd_new_tag); rd_tag = 0 when rd_used = 0; other fields zero
- flush_i  in  1  squash all entries
- count_o  out  CNT_W  valid entry count

## Operation
- Entry state: valid, pc, rob_tag, rs1_tag/rdy, rs2_tag/rdy, rd_tag, rd_used.
- Age matrix: DEPTH×DEPTH bits; age[i][j]=1 means i is older than j.
- Dispatch fire = disp_valid_i & disp_ready_o & ~flush_i.
  - Writes the lowest-index invalid slot.
  - Sets age[j][k]=1 for every currently valid j and clears row k.
- disp_ready_o = (count_o < DEPTH). It is registered state only; there is no combinational path from issue_ready_i.
- Wakeup: when cdb_valid_i is high, any valid entry whose rsN_tag == cdb_tag_i sets rsN_rdy at the edge.
  - Bypass: a packet dispatched in the same cycle with a matching tag is stored with rdy=1 even if its rsN_ready=0.
- Select: ready_vec[i] = valid & rs1_rdy & rs2_rdy. The selected entry is the ready entry with no older ready entry.
  - issue_valid_o = |ready_vec.
  - issue_pkt_o is driven combinationally from the selected entry.
- Issue fire = issue_valid_o & issue_ready_i & ~flush_i. It clears the selected entry's valid bit at the edge.
- If issue_ready_i = 0, the same entry stays offered, or an older entry that became ready. The offer may change between cycles; this is a valid/ready handshake without a hold requirement.
- count_o next = count + dispatch fire − issue fire. Simultaneous dispatch and issue leave the count unchanged.
- flush_i clears all valid bits and sets count to 0 at the edge. It overrides dispatch and issue in the same cycle.

## Timing
- Reset (async assert): all valid=0, count_o=0, disp_ready_o=1, issue_valid_o=0, issue_pkt_o=0.
- Dispatch at edge N (both sources ready) → issue_valid_o high in cycle N+1. No same-cycle pass-through.
- CDB broadcast sampled at edge N → the woken entry is eligible in cycle N+1.
- Issue fire at edge N → the freed slot is reflected in disp_ready_o in cycle N+1.
- Full boundary:
  - At count=DEPTH, disp_ready_o=0 even if an issue fires this cycle.
  - A slot freed by issue is usable the next cycle.
- Empty boundary: at count=0, issue_valid_o=0. A dispatch in the same cycle is not visible until the next cycle.
- Wakeup of a tag matching both sources of one entry sets both rdy bits.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Test plan
- Basic flow: dispatch pc=0x100 with both sources ready, issue_ready_i=1 → issue_valid_o in the next cycle, pkt.pc=0x100, count returns 0 one cycle later.
- Wakeup: dispatch rs1_tag=12 not ready, then cdb_tag_i=12 two cycles later → the entry issues the cycle after the broadcast and never earlier.
  - Same-cycle bypass variant: cdb_tag_i=12 on the dispatch edge → issues the next cycle.
- Age order: dispatch A (rs1 waiting on tag 5), then B, C (ready), then wake tag 5 while issue_ready_i=0. Raise issue_ready_i → issue order is A, B, C.
- Full/backpressure: issue_ready_i=0 and 8 dispatches → disp_ready_o=0 and count_o=8; a ninth packet is held. With one issue, disp_ready_o rises the next cycle and the ninth packet lands in the freed slot.
- Flush: 5 valid entries, flush_i with a concurrent dispatch and issue_ready_i=1 → next cycle count_o=0, issue_valid_o=0, nothing issued, dispatch dropped.
- Reset mid-run: deassert rst_n with 3 entries, one offered → outputs reach reset values without waiting for a clock edge. After release, disp_ready_o=1 and count_o=0.
